// File: rtl/fft_result_reader.sv
// Reads one channel of the finished FFT spectrum and streams it as a byte frame:
// header, channel id, 4 bytes per bin (MSB first), then a modulo-256 checksum.
module fft_result_reader #(
    parameter int         N_BINS   = 128,
    parameter int         ADDR_W   = 8,
    parameter int         DATA_W   = 28,
    parameter int         RD_LAT   = 1,
    parameter logic [7:0] HDR_BYTE = 8'hA5
) (
    input  logic              clk_R,
    input  logic              rst_n,
    input  logic              dv_FFT,
    input  logic              ch_sel,
    output logic [ADDR_W-1:0] AddrFFT_ADC,
    output logic              ReadFFTEn_ADC1,
    output logic              ReadFFTEn_ADC2,
    input  logic [DATA_W-1:0] Data_send_FFT1,
    input  logic [DATA_W-1:0] Data_send_FFT2,
    output logic [7:0]        byte_data,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_CHAN, S_RD, S_WAIT, S_SEND, S_CSUM
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_BIN  = ADDR_W'(N_BINS - 1);
    localparam logic [1:0]        WAIT_LAST = 2'(RD_LAT - 1);

    state_t            state_q, state_d;
    logic              dv_q, dv_d;
    logic              ch_q, ch_d;
    logic [ADDR_W-1:0] bin_q, bin_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [1:0]        wcnt_q, wcnt_d;
    logic [31:0]       shreg_q, shreg_d;
    logic [7:0]        csum_q, csum_d;
    logic [7:0]        byte_data_q, byte_data_d;
    logic              byte_valid_q, byte_valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              en1_q, en1_d;
    logic              en2_q, en2_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              overrun_q, overrun_d;

    logic              start;
    logic              xfer;
    logic [31:0]       cap;

    always_comb begin
        state_d      = state_q;
        dv_d         = dv_FFT;
        ch_d         = ch_q;
        bin_d        = bin_q;
        bcnt_d       = bcnt_q;
        wcnt_d       = wcnt_q;
        shreg_d      = shreg_q;
        csum_d       = csum_q;
        byte_data_d  = byte_data_q;
        byte_valid_d = byte_valid_q;
        addr_d       = addr_q;
        en1_d        = 1'b0;
        en2_d        = 1'b0;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;

        start = dv_FFT & ~dv_q;
        xfer  = byte_valid_q & byte_ready;
        cap   = 32'(ch_q ? Data_send_FFT2 : Data_send_FFT1);

        if (start && state_q != S_IDLE) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                addr_d = '0;
                if (start) begin
                    ch_d         = ch_sel;
                    csum_d       = 8'h00;
                    overrun_d    = 1'b0;
                    bin_d        = '0;
                    busy_d       = 1'b1;
                    byte_valid_d = 1'b1;
                    byte_data_d  = HDR_BYTE;
                    state_d      = S_HDR;
                end
            end
            S_HDR: begin
                if (xfer) begin
                    byte_data_d = ch_q ? 8'h02 : 8'h01;
                    state_d     = S_CHAN;
                end
            end
            S_CHAN: begin
                if (xfer) begin
                    csum_d       = csum_q + byte_data_q;
                    byte_valid_d = 1'b0;
                    addr_d       = bin_q;
                    en1_d        = ~ch_q;
                    en2_d        = ch_q;
                    state_d      = S_RD;
                end
            end
            S_RD: begin
                wcnt_d  = 2'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Sample on the last of the RD_LAT cycles following the strobe
                if (wcnt_q == WAIT_LAST) begin
                    byte_data_d  = cap[31:24];
                    shreg_d      = cap << 8;
                    bcnt_d       = 2'd0;
                    byte_valid_d = 1'b1;
                    state_d      = S_SEND;
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            S_SEND: begin
                if (xfer) begin
                    csum_d = csum_q + byte_data_q;
                    if (bcnt_q != 2'd3) begin
                        byte_data_d = shreg_q[31:24];
                        shreg_d     = shreg_q << 8;
                        bcnt_d      = bcnt_q + 2'd1;
                    end else if (bin_q == LAST_BIN) begin
                        byte_data_d = csum_q + byte_data_q;
                        state_d     = S_CSUM;
                    end else begin
                        bin_d        = bin_q + 1'b1;
                        addr_d       = bin_q + 1'b1;
                        en1_d        = ~ch_q;
                        en2_d        = ch_q;
                        byte_valid_d = 1'b0;
                        state_d      = S_RD;
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    byte_valid_d = 1'b0;
                    byte_data_d  = 8'h00;
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
                    addr_d       = '0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // dv_q resets high so a done level held across reset release is not a start
    always_ff @(posedge clk_R or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            dv_q         <= 1'b1;
            ch_q         <= 1'b0;
            bin_q        <= '0;
            bcnt_q       <= 2'd0;
            wcnt_q       <= 2'd0;
            shreg_q      <= 32'h0;
            csum_q       <= 8'h00;
            byte_data_q  <= 8'h00;
            byte_valid_q <= 1'b0;
            addr_q       <= '0;
            en1_q        <= 1'b0;
            en2_q        <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            dv_q         <= dv_d;
            ch_q         <= ch_d;
            bin_q        <= bin_d;
            bcnt_q       <= bcnt_d;
            wcnt_q       <= wcnt_d;
            shreg_q      <= shreg_d;
            csum_q       <= csum_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            addr_q       <= addr_d;
            en1_q        <= en1_d;
            en2_q        <= en2_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign AddrFFT_ADC    = addr_q;
    assign ReadFFTEn_ADC1 = en1_q;
    assign ReadFFTEn_ADC2 = en2_q;
    assign byte_data      = byte_data_q;
    assign byte_valid     = byte_valid_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_fft_result_reader.sv
// Bench for fft_result_reader: two instances (RD_LAT=1 with 8-bit address, RD_LAT=3 with
// a 2-bit address that wraps at N_BINS) fed by latency-accurate buffer models.
module tb_fft_result_reader;

    logic clk_R = 1'b0;
    always #5 clk_R = ~clk_R;

    logic rst_n, ch_sel, byte_ready, dv0, dv1, act;
    logic [27:0] mem1 [4];
    logic [27:0] mem2 [4];
    logic [27:0] gar;

    logic [7:0]  a_addr, a_bd;
    logic        a_en1, a_en2, a_bv, a_busy, a_fd, a_ov;
    logic [27:0] a_d1, a_d2;
    logic [1:0]  b_addr;
    logic [7:0]  b_bd;
    logic        b_en1, b_en2, b_bv, b_busy, b_fd, b_ov;
    logic [27:0] b_d1, b_d2;

    fft_result_reader #(.N_BINS(4), .ADDR_W(8), .DATA_W(28), .RD_LAT(1), .HDR_BYTE(8'hA5)) u_dut_a (
        .clk_R(clk_R), .rst_n(rst_n), .dv_FFT(dv0), .ch_sel(ch_sel),
        .AddrFFT_ADC(a_addr), .ReadFFTEn_ADC1(a_en1), .ReadFFTEn_ADC2(a_en2),
        .Data_send_FFT1(a_d1), .Data_send_FFT2(a_d2),
        .byte_data(a_bd), .byte_valid(a_bv), .byte_ready(byte_ready),
        .busy(a_busy), .frame_done(a_fd), .overrun(a_ov));

    fft_result_reader #(.N_BINS(4), .ADDR_W(2), .DATA_W(28), .RD_LAT(3), .HDR_BYTE(8'hA5)) u_dut_b (
        .clk_R(clk_R), .rst_n(rst_n), .dv_FFT(dv1), .ch_sel(ch_sel),
        .AddrFFT_ADC(b_addr), .ReadFFTEn_ADC1(b_en1), .ReadFFTEn_ADC2(b_en2),
        .Data_send_FFT1(b_d1), .Data_send_FFT2(b_d2),
        .byte_data(b_bd), .byte_valid(b_bv), .byte_ready(byte_ready),
        .busy(b_busy), .frame_done(b_fd), .overrun(b_ov));

    // Result buffers: data is valid only RD_LAT cycles after the strobe, garbage otherwise
    logic       a_v1, a_v2;
    logic [1:0] a_pa;
    logic [2:0] b_v1p, b_v2p;
    logic [1:0] b_pa [3];
    always @(posedge clk_R) begin
        gar   <= 28'($urandom);
        a_v1  <= a_en1;
        a_v2  <= a_en2;
        a_pa  <= a_addr[1:0];
        b_v1p <= {b_v1p[1:0], b_en1};
        b_v2p <= {b_v2p[1:0], b_en2};
        b_pa[2] <= b_pa[1];
        b_pa[1] <= b_pa[0];
        b_pa[0] <= b_addr;
    end
    assign a_d1 = a_v1     ? mem1[a_pa]    : gar;
    assign a_d2 = a_v2     ? mem2[a_pa]    : ~gar;
    assign b_d1 = b_v1p[2] ? mem1[b_pa[2]] : gar;
    assign b_d2 = b_v2p[2] ? mem2[b_pa[2]] : ~gar;

    logic [7:0] addr, bd;
    logic       en1, en2, bv, busy, fd, ov;
    assign addr = act ? {6'b0, b_addr} : a_addr;
    assign bd   = act ? b_bd   : a_bd;
    assign en1  = act ? b_en1  : a_en1;
    assign en2  = act ? b_en2  : a_en2;
    assign bv   = act ? b_bv   : a_bv;
    assign busy = act ? b_busy : a_busy;
    assign fd   = act ? b_fd   : a_fd;
    assign ov   = act ? b_ov   : a_ov;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_dv(input logic v);
        if (act) dv1 = v;
        else     dv0 = v;
    endtask

    // Reference frame: header, channel id, bins as zero-extended 32-bit words MSB first, checksum
    task automatic build_exp(input logic ch);
        int sum;
        int w;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        sum = ch ? 2 : 1;
        exp_q.push_back(8'(sum));
        for (int b = 0; b < 4; b++) begin
            w = int'(ch ? mem2[b] : mem1[b]);
            for (int k = 3; k >= 0; k--) begin
                int by;
                by = (w >> (8 * k)) & 255;
                exp_q.push_back(8'(by));
                sum = (sum + by) % 256;
            end
        end
        exp_q.push_back(8'(sum));
    endtask

    // mode 0: plain frame, 1: second start during bin-2 SEND, 2: reset during bin-1 SEND
    task automatic run_frame(input int mode, input bit rnd, input string nm);
        logic [7:0] obs [$];
        int st_addr [$];
        int st_cyc [$];
        int n_done = 0, n_wrong = 0, viol = 0, cyc = 0, inj = 0, lat, cnt;
        bit hold = 0, done_prev = 0, finished = 0;
        logic [7:0] pbd = 8'h00;
        lat = act ? 3 : 1;
        build_exp(ch_sel);
        byte_ready = 1'b0;
        set_dv(1'b0);
        repeat (2) @(negedge clk_R);
        set_dv(1'b1);
        for (int i = 0; i < 3000 && !finished; i++) begin
            @(negedge clk_R);
            cyc++;
            byte_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (hold && !(bv && bd == pbd)) viol++;
            if (ch_sel ? en1 : en2) n_wrong++;
            if (ch_sel ? en2 : en1) begin
                st_addr.push_back(int'(addr));
                st_cyc.push_back(cyc);
            end
            if (fd) n_done++;
            if (bv && byte_ready) obs.push_back(bd);
            hold = bv && !byte_ready;
            pbd  = bd;
            if (mode == 1) begin
                if (inj == 0 && st_cyc.size() == 3 && bv) begin
                    set_dv(1'b0);
                    inj = 1;
                end else if (inj == 1) begin
                    set_dv(1'b1);
                    inj = 2;
                end
            end
            if (mode == 2 && st_cyc.size() == 2 && bv) begin
                rst_n = 1'b0;
                #1;
                check({nm, "_reset_outputs"}, int'({bv, busy, en1, en2, fd, ov, addr, bd}), 0);
                @(negedge clk_R);
                rst_n = 1'b1;
                cnt = 0;
                repeat (10) begin
                    @(negedge clk_R);
                    if (busy || bv || en1 || en2) cnt++;
                end
                check({nm, "_no_start_dv_held"}, cnt, 0);
                return;
            end
            if (done_prev) finished = 1;
            done_prev = fd;
        end
        check({nm, "_completed"}, int'(finished), 1);
        check({nm, "_byte_count"}, obs.size(), exp_q.size());
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
            check($sformatf("%s_byte%0d", nm, i), int'(obs[i]), int'(exp_q[i]));
        check({nm, "_frame_done_pulses"}, n_done, 1);
        check({nm, "_other_strobe"}, n_wrong, 0);
        check({nm, "_strobe_count"}, st_addr.size(), 4);
        for (int i = 0; i < st_addr.size(); i++)
            check($sformatf("%s_strobe_addr%0d", nm, i), st_addr[i], i);
        if (!rnd)
            for (int i = 1; i < st_cyc.size(); i++)
                check($sformatf("%s_bin_cycles%0d", nm, i), st_cyc[i] - st_cyc[i-1], 1 + lat + 4);
        check({nm, "_hold_stable"}, viol, 0);
        check({nm, "_idle_after"}, int'({busy, bv, fd}), 0);
        check({nm, "_overrun"}, int'(ov), (mode == 1) ? 1 : 0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 4; i++) begin
            mem1[i] = 28'($urandom);
            mem2[i] = 28'($urandom);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        dv0 = 1'b0;
        dv1 = 1'b0;
        ch_sel = 1'b0;
        byte_ready = 1'b0;
        act = 1'b0;
        fill_random();
        repeat (3) @(negedge clk_R);
        check("reset_a", int'({a_bv, a_busy, a_en1, a_en2, a_fd, a_ov, a_addr, a_bd}), 0);
        check("reset_b", int'({b_bv, b_busy, b_en1, b_en2, b_fd, b_ov, b_addr, b_bd}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_R);

        ch_sel = 1'b1;
        for (int i = 0; i < 4; i++) mem2[i] = 28'(i);
        run_frame(0, 0, "adc2_ramp");

        ch_sel = 1'b0;
        for (int i = 0; i < 4; i++) mem1[i] = 28'hABCDEF1;
        run_frame(0, 0, "adc1_const");

        ch_sel = 1'b1;
        for (int i = 0; i < 4; i++) mem2[i] = 28'(i);
        run_frame(0, 1, "adc2_backpressure");

        run_frame(1, 0, "overrun");
        run_frame(0, 0, "overrun_cleared");

        fill_random();
        run_frame(2, 0, "reset_abort");
        run_frame(0, 0, "after_reset");

        for (int r = 0; r < 3; r++) begin
            fill_random();
            ch_sel = 1'($urandom_range(0, 1));
            run_frame(0, 1'($urandom_range(0, 1)), $sformatf("rand_lat1_%0d", r));
        end

        act = 1'b1;
        for (int r = 0; r < 3; r++) begin
            fill_random();
            ch_sel = 1'($urandom_range(0, 1));
            run_frame(0, (r == 2), $sformatf("lat3_%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
